// File: rtl/lcd_bus_arbiter_if.sv
// rtl/lcd_bus_arbiter_if.sv - two-requester byte handshake plus HD44780 4-bit bus bundle
interface lcd_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       en;
  logic       rs;
  logic [3:0] data;
  logic       busy;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready, en, rs, data, busy
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready, en, rs, data, busy
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - arbitrates two byte requesters onto an HD44780 4-bit bus
// Optional feature: define LCD_ARB_ROUNDROBIN_EN for alternating grant on contention.
module lcd_bus_arbiter #(
  parameter int LONG_WAIT  = 2,
  parameter int SHORT_WAIT = 0
) (
  input logic              clk,
  input logic              reset,
  lcd_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HI_EN, HI_DIS, LO_EN, LO_DIS, WAIT} state_t;

  localparam int MAX_WAIT = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
  localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t          state, state_nxt;
  logic [7:0]      byte_q;
  logic            rs_q;
  logic [3:0]      data_q;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_load;
  logic            grant0, grant1, accept, is_long, prefer0;

`ifdef LCD_ARB_ROUNDROBIN_EN
  logic last_grant;
  assign prefer0 = last_grant;
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.req0_valid && (!bus.req1_valid || prefer0)) grant0 = 1'b1;
      else if (bus.req1_valid)                            grant1 = 1'b1;
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Clear/home commands need the controller's long execution time.
  assign is_long   = !rs_q && (byte_q inside {8'h01, 8'h02, 8'h03});
  assign wait_load = is_long ? CW'(LONG_WAIT) : CW'(SHORT_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HI_EN;
      HI_EN:   state_nxt = HI_DIS;
      HI_DIS:  state_nxt = LO_EN;
      LO_EN:   state_nxt = LO_DIS;
      LO_DIS:  state_nxt = (wait_load == '0) ? IDLE : WAIT;
      WAIT:    if (wait_cnt <= CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.en   = (state == HI_EN) || (state == LO_EN);
  assign bus.busy = (state != IDLE);
  assign bus.rs   = rs_q;
  assign bus.data = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      data_q   <= '0;
      wait_cnt <= '0;
`ifdef LCD_ARB_ROUNDROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          byte_q <= grant0 ? bus.req0_data : bus.req1_data;
          rs_q   <= grant0 ? bus.req0_rs   : bus.req1_rs;
          data_q <= grant0 ? bus.req0_data[7:4] : bus.req1_data[7:4];
`ifdef LCD_ARB_ROUNDROBIN_EN
          last_grant <= grant1;
`endif
        end
        HI_DIS:  data_q   <= byte_q[3:0];
        LO_DIS:  wait_cnt <= wait_load;
        WAIT:    if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - randomized scoreboard bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  localparam int LW = 2;
  localparam int SW = 0;

  typedef struct {
    int         acc;
    logic       rs;
    logic [7:0] b;
    int         wt;
  } exp_t;

  logic clk;
  logic reset;
  lcd_bus_arbiter_if bus_if();

  lcd_bus_arbiter #(.LONG_WAIT(LW), .SHORT_WAIT(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   mon_on = 0;
  int   last_accept = -100;
  int   last_end = -100;
  bit   have_prev = 0;
  int   m_last = 1;
  bit   second = 0;
  bit   have_hold = 0;
  logic hold_rs;
  logic [3:0] hold_data;
  logic [3:0] got_hi;
  logic got_hrs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_wait(input logic r, input logic [7:0] b);
    return (!r && b >= 8'h01 && b <= 8'h03) ? LW : SW;
  endfunction

  task automatic do_txn(input int pat, input logic r0, input logic [7:0] d0,
                        input logic r1, input logic [7:0] d1);
    int   g;
    bit   got;
    exp_t e;
    @(negedge clk);
    bus_if.req0_valid = (pat == 1 || pat == 3);
    bus_if.req1_valid = (pat == 2 || pat == 3);
    bus_if.req0_rs = r0;
    bus_if.req0_data = d0;
    bus_if.req1_rs = r1;
    bus_if.req1_data = d1;
    if (pat == 1) g = 0;
    else if (pat == 2) g = 1;
`ifdef LCD_ARB_ROUNDROBIN_EN
    else g = (m_last == 1) ? 0 : 1;
`else
    else g = 0;
`endif
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus_if.req0_ready || bus_if.req1_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("grant", {bus_if.req1_ready, bus_if.req0_ready}, (g == 0) ? 32'd1 : 32'd2);
      if (have_prev) chk("accept_time", cyc, last_end);
      e.acc = cyc;
      e.rs  = (g == 0) ? r0 : r1;
      e.b   = (g == 0) ? d0 : d1;
      e.wt  = model_wait(e.rs, e.b);
      q.push_back(e);
      m_last      = g;
      last_accept = cyc;
      last_end    = cyc + 5 + e.wt;
      have_prev   = 1;
      @(posedge clk);
    end
  endtask

  // Monitor: checks bus pulses against the scoreboard, plus busy and idle hold.
  always begin
    @(negedge clk);
    #2;
    if (mon_on) begin
      chk("busy", bus_if.busy, (cyc > last_accept && cyc < last_end));
      if (bus_if.en) begin
        if (q.size() == 0) begin
          chk("unexpected_en", 32'd1, 32'd0);
        end else if (!second) begin
          chk("hi_time", cyc, q[0].acc + 1);
          got_hi  = bus_if.data;
          got_hrs = bus_if.rs;
          second  = 1;
        end else begin
          chk("lo_time", cyc, q[0].acc + 3);
          chk("hi_rs", got_hrs, q[0].rs);
          chk("lo_rs", bus_if.rs, q[0].rs);
          chk("hi_nibble", got_hi, q[0].b[7:4]);
          chk("lo_nibble", bus_if.data, q[0].b[3:0]);
          hold_rs   = q[0].rs;
          hold_data = q[0].b[3:0];
          have_hold = 1;
          second    = 0;
          void'(q.pop_front());
        end
      end else if (!bus_if.busy && have_hold) begin
        chk("hold_rs", bus_if.rs, hold_rs);
        chk("hold_data", bus_if.data, hold_data);
      end
    end
  end

  initial begin
    int ok;
    int en_cnt;
    reset = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    bus_if.req0_rs = 1'b1;
    bus_if.req1_rs = 1'b1;
    bus_if.req0_data = 8'hFF;
    bus_if.req1_data = 8'hFF;
    #3;
    chk("rst_en", bus_if.en, 0);
    chk("rst_rs", bus_if.rs, 0);
    chk("rst_data", bus_if.data, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_ready", {bus_if.req1_ready, bus_if.req0_ready}, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready_clk", {bus_if.req1_ready, bus_if.req0_ready}, 0);
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    reset = 1'b0;
    mon_on = 1;

    do_txn(1, 1'b1, 8'h41, 1'b0, 8'h00);
    do_txn(2, 1'b1, 8'h99, 1'b0, 8'h01);
    do_txn(1, 1'b1, 8'h28, 1'b1, 8'h55);
    do_txn(1, 1'b1, 8'h0C, 1'b0, 8'h02);
    do_txn(1, 1'b1, 8'h01, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) do_txn(3, 1'b1, 8'h30 + 8'(i), 1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      do_txn($urandom_range(1, 3), 1'($urandom), a, 1'($urandom), b);
    end

    @(negedge clk);
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0 && !bus_if.busy) ok = 1;
    end
    chk("drain", ok, 1);
    mon_on = 0;

    // Reset landing in LO_EN must drop the bus at once and abandon the byte.
    @(negedge clk);
    bus_if.req0_valid = 1'b1;
    bus_if.req0_rs = 1'b1;
    bus_if.req0_data = 8'h41;
    #1;
    chk("dir_ready", bus_if.req0_ready, 1);
    @(posedge clk);
    #1;
    bus_if.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("dir_lo_en", bus_if.en, 1);
    chk("dir_lo_data", bus_if.data, 4'h1);
    reset = 1'b1;
    #1;
    chk("arst_en", bus_if.en, 0);
    chk("arst_data", bus_if.data, 0);
    chk("arst_rs", bus_if.rs, 0);
    chk("arst_busy", bus_if.busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.en) en_cnt++;
    end
    chk("no_en_after_reset", en_cnt, 0);
    chk("idle_after_reset", bus_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
